digit_crossing_features: RTL and testbench

//  Stage directly downstream of horizontal_projection. Takes the digit bounding box (left/right from the

---
 rtl/digit_crossing_features_if.sv | 28 ++
 rtl/digit_crossing_features.sv | 140 ++++++++++++++
 tb/tb_digit_crossing_features.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/digit_crossing_features_if.sv
// Pixel stream, bounding box and published crossing features between
// horizontal_projection (master side) and digit_crossing_features (slave side).
interface digit_crossing_features_if #(
  parameter int CNT_W = 4
);
  logic             vsync;
  logic             clken;
  logic             bin;
  logic [10:0]      line_left;
  logic [10:0]      line_right;
  logic [10:0]      line_top;
  logic [10:0]      line_bottom;
  logic [CNT_W-1:0] v_cross;
  logic [CNT_W-1:0] h1_cross;
  logic [CNT_W-1:0] h2_cross;
  logic             box_ok;
  logic             feat_valid;

  modport master (
    output vsync, clken, bin, line_left, line_right, line_top, line_bottom,
    input  v_cross, h1_cross, h2_cross, box_ok, feat_valid
  );

  modport slave (
    input  vsync, clken, bin, line_left, line_right, line_top, line_bottom,
    output v_cross, h1_cross, h2_cross, box_ok, feat_valid
  );
endinterface

// File: rtl/digit_crossing_features.sv
// Counts 0->1 stroke crossings on one vertical and two horizontal scan lines
// inside the digit bounding box; publishes the three counts once per frame.
module digit_crossing_features #(
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int CNT_W          = 4,
  parameter int MIN_SPAN       = 3
) (
  input logic                     clk,
  input logic                     reset,
  digit_crossing_features_if.slave bus
);
  typedef enum logic [1:0] {S_WAIT, S_ARM, S_SCAN, S_DONE} state_t;

  localparam logic [10:0]      X_LAST  = 11'(DISPLAY_WIDTH - 1);
  localparam logic [10:0]      Y_LAST  = 11'(DISPLAY_HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [10:0]      x_cnt, y_cnt;
  logic [10:0]      box_l, box_r, box_t, box_b;
  logic [10:0]      xm, y1, y2;
  logic             vprev, hprev;
  logic [CNT_W-1:0] v_cnt, h1_cnt, h2_cnt;
  logic [CNT_W-1:0] v_out, h1_out, h2_out;
  logic             box_ok_out, feat_valid_out;

  // 13-bit sums so 3*top+bottom cannot overflow before the shift
  logic [12:0] xm_sum, y1_sum, y2_sum;
  assign xm_sum = {2'b0, bus.line_left} + {2'b0, bus.line_right};
  assign y1_sum = ({2'b0, bus.line_top} << 1) + {2'b0, bus.line_top} + {2'b0, bus.line_bottom};
  assign y2_sum = ({2'b0, bus.line_bottom} << 1) + {2'b0, bus.line_bottom} + {2'b0, bus.line_top};

  logic on_col, on_span, on_row1, on_row2, box_valid;
  assign on_col    = (x_cnt == xm) && (y_cnt >= box_t) && (y_cnt <= box_b);
  assign on_span   = (x_cnt > box_l) && (x_cnt < box_r);
  assign on_row1   = on_span && (y_cnt == y1);
  assign on_row2   = on_span && (y_cnt == y2);
  assign box_valid = ({1'b0, box_r} >= {1'b0, box_l} + 12'(MIN_SPAN)) &&
                     ({1'b0, box_b} >= {1'b0, box_t} + 12'(MIN_SPAN));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (!bus.vsync) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (bus.clken) begin
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        if (y_cnt != Y_LAST) y_cnt <= y_cnt + 11'd1;
      end else begin
        x_cnt <= x_cnt + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_WAIT;
      box_l          <= '0;
      box_r          <= '0;
      box_t          <= '0;
      box_b          <= '0;
      xm             <= '0;
      y1             <= '0;
      y2             <= '0;
      vprev          <= 1'b0;
      hprev          <= 1'b0;
      v_cnt          <= '0;
      h1_cnt         <= '0;
      h2_cnt         <= '0;
      v_out          <= '0;
      h1_out         <= '0;
      h2_out         <= '0;
      box_ok_out     <= 1'b0;
      feat_valid_out <= 1'b0;
    end else begin
      case (state)
        S_WAIT: if (!bus.vsync) state <= S_ARM;
        S_ARM: if (bus.vsync) begin
          box_l  <= bus.line_left;
          box_r  <= bus.line_right;
          box_t  <= bus.line_top;
          box_b  <= bus.line_bottom;
          xm     <= xm_sum[11:1];
          y1     <= y1_sum[12:2];
          y2     <= y2_sum[12:2];
          v_cnt  <= '0;
          h1_cnt <= '0;
          h2_cnt <= '0;
          vprev  <= 1'b0;
          hprev  <= 1'b0;
          state  <= S_SCAN;
        end
        S_SCAN: begin
          if (!bus.vsync) begin
            v_out          <= v_cnt;
            h1_out         <= h1_cnt;
            h2_out         <= h2_cnt;
            box_ok_out     <= box_valid;
            feat_valid_out <= 1'b1;
            state          <= S_DONE;
          end else if (bus.clken) begin
            if (on_col) begin
              if (bus.bin && !vprev) v_cnt <= sat_inc(v_cnt);
              vprev <= bus.bin;
            end
            // hprev shared by both rows; they never overlap unless y1==y2
            if (x_cnt == '0) begin
              hprev <= 1'b0;
            end else if (on_row1 || on_row2) begin
              if (bus.bin && !hprev) begin
                if (on_row1) h1_cnt <= sat_inc(h1_cnt);
                if (on_row2) h2_cnt <= sat_inc(h2_cnt);
              end
              hprev <= bus.bin;
            end
          end
        end
        S_DONE: begin
          feat_valid_out <= 1'b0;
          state          <= S_ARM;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  assign bus.v_cross    = v_out;
  assign bus.h1_cross   = h1_out;
  assign bus.h2_cross   = h2_out;
  assign bus.box_ok     = box_ok_out;
  assign bus.feat_valid = feat_valid_out;
endmodule

// File: tb/tb_digit_crossing_features.sv
// Scoreboard bench: frames drawn into an image array, expected features derived
// from the image along each scan line and checked when feat_valid pulses.
module tb_digit_crossing_features;
  localparam int W = 48;
  localparam int H = 40;

  typedef struct {
    int     v, h1, h2, ok;
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  longint cyc = 0;
  int     errors = 0;
  int     checks = 0;
  exp_t   q[$];
  bit     img [0:H-1][0:W-1];

  digit_crossing_features_if #(.CNT_W(4)) bus();

  digit_crossing_features #(
    .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .CNT_W(4), .MIN_SPAN(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pixel (x,y) exists only if the stream delivered it before vsync fell
  function automatic bit present(int x, int y, int npix);
    return (x >= 0) && (x < W) && (y >= 0) && (y < H) && (y * W + x < npix);
  endfunction

  function automatic int sat(int c);
    return (c > 15) ? 15 : c;
  endfunction

  function automatic int cross_col(int col, int lo, int hi, int npix);
    int c = 0;
    bit p = 0;
    for (int y = lo; y <= hi && y < H; y++)
      if (present(col, y, npix)) begin
        if (img[y][col] && !p) c++;
        p = img[y][col];
      end
    return sat(c);
  endfunction

  function automatic int cross_row(int row, int l, int r, int npix);
    int c = 0;
    bit p = 0;
    for (int x = l + 1; x < r && x < W; x++)
      if (present(x, row, npix)) begin
        if (img[row][x] && !p) c++;
        p = img[row][x];
      end
    return sat(c);
  endfunction

  task automatic clear_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 0;
  endtask

  task automatic draw_ring();
    clear_img();
    for (int y = 8; y <= 27; y++)
      for (int x = 14; x <= 36; x++)
        img[y][x] = !((y >= 11) && (y <= 24) && (x >= 17) && (x <= 33));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_v"}, bus.v_cross, 0);
    chk({tag, "_h1"}, bus.h1_cross, 0);
    chk({tag, "_h2"}, bus.h2_cross, 0);
    chk({tag, "_ok"}, bus.box_ok, 0);
    chk({tag, "_fv"}, bus.feat_valid, 0);
  endtask

  // duty: % chance of clken per cycle; abort_n: pixel index where reset hits (-1 none)
  task automatic run_frame(input int l, r, t, b, npix, duty, abort_n);
    exp_t e;
    bit   aborted = 0;
    int   idle;
    bus.line_left   = 11'(l);
    bus.line_right  = 11'(r);
    bus.line_top    = 11'(t);
    bus.line_bottom = 11'(b);
    bus.vsync = 0;
    bus.clken = 0;
    bus.bin   = 0;
    repeat (3) step();
    bus.vsync = 1;
    repeat (2) step();
    for (int n = 0; n < npix; n++) begin
      idle = 0;
      while (duty < 100 && $urandom_range(99) >= duty && idle < 8) begin
        bus.clken = 0;
        bus.bin   = $urandom_range(1);
        step();
        idle++;
      end
      if (n == abort_n) begin
        aborted   = 1;
        reset     = 1;
        bus.clken = 0;
        step();
        step();
        chk_zero_outputs("midreset");
        reset = 0;
      end
      bus.clken = 1;
      bus.bin   = img[n / W][n % W];
      step();
    end
    bus.clken = 0;
    bus.bin   = 0;
    bus.vsync = 0;
    if (!aborted) begin
      e.v   = cross_col((l + r) >> 1, t, b, npix);
      e.h1  = cross_row((3 * t + b) >> 2, l, r, npix);
      e.h2  = cross_row((t + 3 * b) >> 2, l, r, npix);
      e.ok  = (r >= l + 3) && (b >= t + 3);
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    repeat (4) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.feat_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_feat_valid at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("v_cross", bus.v_cross, e.v);
        chk("h1_cross", bus.h1_cross, e.h1);
        chk("h2_cross", bus.h2_cross, e.h2);
        chk("box_ok", bus.box_ok, e.ok);
        chk("publish_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.vsync = 0;
    bus.clken = 0;
    bus.bin   = 0;
    bus.line_left = '0;
    bus.line_right = '0;
    bus.line_top = '0;
    bus.line_bottom = '0;
    step();
    chk_zero_outputs("reset");
    reset = 0;
    step();

    // solid vertical bar through the box
    clear_img();
    for (int y = 0; y < H; y++)
      for (int x = 22; x <= 27; x++) img[y][x] = 1;
    run_frame(10, 40, 5, 30, W * H, 100, -1);

    // hollow ring
    draw_ring();
    run_frame(10, 40, 5, 30, W * H, 100, -1);

    // alternating column saturates the vertical count
    clear_img();
    for (int y = 0; y < H; y++) img[y][25] = y[0];
    run_frame(10, 40, 2, 38, W * H, 100, -1);

    // degenerate box, strokes outside it
    clear_img();
    for (int y = 0; y < H; y++)
      for (int x = 30; x < W; x++) img[y][x] = 1;
    run_frame(10, 11, 5, 30, W * H, 100, -1);

    // reset mid-frame: no publish, then a normal frame
    draw_ring();
    run_frame(10, 40, 5, 30, W * H, 100, 20 * W);
    run_frame(10, 40, 5, 30, W * H, 100, -1);

    // ring with 50% clken gaps
    run_frame(10, 40, 5, 30, W * H, 50, -1);

    // short frame: vsync drops partway through the ring
    run_frame(10, 40, 5, 30, 24 * W + 20, 100, -1);

    // top==bottom gives y1==y2
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = ($urandom_range(2) == 0);
    run_frame(5, 44, 15, 15, W * H, 70, -1);

    // random boxes, images, frame lengths and clken duty
    for (int k = 0; k < 4; k++) begin
      int l, t, dens;
      dens = $urandom_range(1, 3);
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) img[y][x] = ($urandom_range(3) < dens);
      l = $urandom_range(0, 30);
      t = $urandom_range(0, 25);
      run_frame(l, l + $urandom_range(0, 17), t, t + $urandom_range(0, 14),
                (k == 2) ? $urandom_range(W, W * H - 1) : W * H,
                $urandom_range(40, 100), -1);
    end

    repeat (5) step();
    chk("pending_publishes", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
